// File: rtl/dispatch_sink_pkg.sv
// -----------------------------------------------------------------------------
// dispatch_sink_pkg
// Shared types and helpers for the dispatch sink stream:
//   state_e       drain engine states (IDLE, HEADER, BODY)
//   mode_e        per-frame encoding (index list or packed bitmap)
//   popcount()    number of set bits in a fire vector
//   msb_index()   position of the highest set bit (0 when the vector is empty)
//   num_chunks()  ceil(n / w), the beat count of a bitmap frame
// Vectors are passed zero-extended to MAX_OUT bits so that one function serves
// every NUM_OUT up to that bound.
// -----------------------------------------------------------------------------
package dispatch_sink_pkg;

  localparam int MAX_OUT = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    BODY   = 2'd2
  } state_e;

  typedef enum logic {
    MODE_INDEX  = 1'b0,
    MODE_BITMAP = 1'b1
  } mode_e;

  function automatic int popcount(input logic [MAX_OUT-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_OUT; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int msb_index(input logic [MAX_OUT-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_OUT; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  function automatic int num_chunks(input int n, input int w);
    return (n + w - 1) / w;
  endfunction

endpackage

// File: rtl/sink_frame_fifo.sv
// -----------------------------------------------------------------------------
// sink_frame_fifo
// Frame queue between the network capture side and the drain engine.
// Ports:
//   clk, arstn        clock, asynchronous active-low reset
//   i_clr             synchronous flush (pointers and count to zero)
//   i_push, i_data    write one frame (ignored when full)
//   i_pop             retire the head frame (ignored when empty)
//   o_head            head frame, valid while !o_empty
//   o_full, o_empty   occupancy flags
// -----------------------------------------------------------------------------
module sink_frame_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CNTW-1:0]  r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CNTW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];

  // NOTE: storage has no reset; the count and pointers alone decide what is
  // valid, and leaving the array unreset lets it map onto plain flops/LUT RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop_ok)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dispatch_sink_stream.sv
// -----------------------------------------------------------------------------
// dispatch_sink_stream
// Captures network fire vectors into a frame FIFO and drains each frame onto a
// narrow valid/ready sink stream, either as an index list (count header, then
// set-bit indices in descending order) or as a packed bitmap (LSB chunk first).
// Ports:
//   clk, arstn            clock, asynchronous active-low reset
//   clr                   synchronous flush of FIFO and drain engine
//   mode                  frame mode sampled with net_out (0 index, 1 bitmap)
//   net_valid/net_ready   frame handshake, net_out is the fire vector
//   snk_valid/snk_ready   beat handshake, snk is the beat, snk_last ends frame
// -----------------------------------------------------------------------------
module dispatch_sink_stream
  import dispatch_sink_pkg::*;
#(
  parameter int NUM_OUT     = 8,
  parameter int SNK_WIDTH   = $clog2(NUM_OUT + 1),
  parameter int FRAME_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 clr,
  input  logic                 mode,
  input  logic                 net_valid,
  output logic                 net_ready,
  input  logic [NUM_OUT-1:0]   net_out,
  input  logic                 snk_ready,
  output logic                 snk_valid,
  output logic [SNK_WIDTH-1:0] snk,
  output logic                 snk_last
);

  localparam int CW   = $clog2(NUM_OUT + 1);
  localparam int NCH  = num_chunks(NUM_OUT, SNK_WIDTH);
  localparam int CHW  = $clog2(NCH + 1);
  localparam int PADW = NCH * SNK_WIDTH;

  if (SNK_WIDTH < CW) begin : g_bad_snk_width
    $error("SNK_WIDTH too narrow for an index or count beat");
  end
  if (NUM_OUT > MAX_OUT) begin : g_bad_num_out
    $error("NUM_OUT exceeds the package helper width");
  end

  logic [NUM_OUT:0]     w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_hs;

  state_e               r_state;
  mode_e                r_mode;
  logic [NUM_OUT-1:0]   r_work;
  logic [CW-1:0]        r_cnt;
  logic [CHW-1:0]       r_chunk;
  logic                 r_head_ok;

  logic [CW-1:0]        w_msb;
  logic                 w_one_left;
  logic [PADW-1:0]      w_pad;
  logic [SNK_WIDTH-1:0] w_chunk_data;
  logic                 w_chunk_last;

  assign net_ready = !w_full;
  assign w_push    = net_valid && !w_full && !clr;
  assign w_hs      = snk_valid && snk_ready;
  assign w_pop     = w_hs && snk_last && !clr;

  sink_frame_fifo #(
    .WIDTH (NUM_OUT + 1),
    .DEPTH (FRAME_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .arstn   (arstn),
    .i_clr   (clr),
    .i_push  (w_push),
    .i_data  ({mode, net_out}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_msb        = CW'(msb_index(MAX_OUT'(r_work)));
  assign w_one_left   = (popcount(MAX_OUT'(r_work)) == 1);
  assign w_pad        = PADW'(r_work);
  assign w_chunk_data = SNK_WIDTH'(w_pad >> (int'(r_chunk) * SNK_WIDTH));
  assign w_chunk_last = (r_chunk == CHW'(NCH - 1));

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    snk_valid = 1'b0;
    snk       = '0;
    snk_last  = 1'b0;
    case (r_state)
      HEADER: begin
        snk_valid = 1'b1;
        snk       = SNK_WIDTH'(r_cnt);
        snk_last  = (r_cnt == '0);
      end
      BODY: begin
        snk_valid = 1'b1;
        if (r_mode == MODE_INDEX) begin
          snk      = SNK_WIDTH'(w_msb);
          snk_last = w_one_left;
        end else begin
          snk      = w_chunk_data;
          snk_last = w_chunk_last;
        end
      end
      default: ;
    endcase
  end

  // r_head_ok delays head visibility by one cycle after the FIFO turns
  // non-empty, so a frame written into an empty FIFO is loaded on the second
  // edge after capture. Back-to-back frames already resident see it high.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state   <= IDLE;
      r_mode    <= MODE_INDEX;
      r_work    <= '0;
      r_cnt     <= '0;
      r_chunk   <= '0;
      r_head_ok <= 1'b0;
    end else if (clr) begin
      r_state   <= IDLE;
      r_head_ok <= 1'b0;
    end else begin
      r_head_ok <= !w_empty;
      case (r_state)
        IDLE: begin
          if (r_head_ok && !w_empty) begin
            r_work  <= w_head[NUM_OUT-1:0];
            r_mode  <= mode_e'(w_head[NUM_OUT]);
            r_cnt   <= CW'(popcount(MAX_OUT'(w_head[NUM_OUT-1:0])));
            r_chunk <= '0;
            r_state <= w_head[NUM_OUT] ? BODY : HEADER;
          end
        end
        HEADER: begin
          if (w_hs) r_state <= (r_cnt == '0) ? IDLE : BODY;
        end
        BODY: begin
          if (w_hs) begin
            if (r_mode == MODE_INDEX) r_work <= r_work & ~(NUM_OUT'(1) << w_msb);
            else                      r_chunk <= r_chunk + 1'b1;
            if (snk_last) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
